// File: rtl/mac_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_ctrl_if : memory, MAC and result bus between mac_ctrl and its peers  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface mac_ctrl_if #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 4
);
  localparam int c_IAW = $clog2(N_IN);
  localparam int c_OAW = $clog2(N_OUT);
  localparam int c_WAW = $clog2(N_IN * N_OUT);

  logic        [c_IAW-1:0] in_addr;
  logic signed [7:0]       in_data;
  logic        [c_WAW-1:0] wt_addr;
  logic signed [7:0]       wt_data;
  logic signed [7:0]       mac_a;
  logic signed [7:0]       mac_b;
  logic                    mac_clr_n;
  logic signed [15:0]      mac_acc;
  logic                    mac_of;
  logic                    mac_uf;
  logic signed [7:0]       res;
  logic        [c_OAW-1:0] res_addr;
  logic                    res_we;

  modport master (
    output in_addr, wt_addr, mac_a, mac_b, mac_clr_n, res, res_addr, res_we,
    input  in_data, wt_data, mac_acc, mac_of, mac_uf
  );

  modport slave (
    input  in_addr, wt_addr, mac_a, mac_b, mac_clr_n, res, res_addr, res_we,
    output in_data, wt_data, mac_acc, mac_of, mac_uf
  );
endinterface
`default_nettype wire

// File: rtl/mac_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_ctrl : sequences N_OUT dot products of N_IN terms through a MAC      |
// | Optional saturation of results: define MAC_CTRL_SAT_EN                   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mac_ctrl #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 4,
  parameter int SHIFT = 4
) (
  input  wire        clk,
  input  wire        rst_n,
  input  wire        start,
  output logic       busy,
  output logic       done,
  mac_ctrl_if.master bus
);
  localparam int c_IAW = $clog2(N_IN);
  localparam int c_OAW = $clog2(N_OUT);
  localparam int c_WAW = $clog2(N_IN * N_OUT);
  localparam int c_KW  = $clog2(N_IN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_ACC   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_OAW-1:0]   r_n;
  logic [c_KW-1:0]    r_k;
  logic               r_sticky_of;
  logic               r_sticky_uf;
  logic               r_busy;
  logic               r_done;
  logic [7:0]         r_res;
  logic [c_OAW-1:0]   r_res_addr;
  logic               r_res_we;
  logic [c_IAW-1:0]   r_in_addr;
  logic [c_WAW-1:0]   r_wt_addr;
  logic               r_clr_n;

  logic               w_of_seen;
  logic               w_uf_seen;
  logic signed [15:0] w_shifted;
  logic [7:0]         w_res;

  // Whichever flag appears first owns the neuron; overflow wins a same-cycle tie.
  assign w_of_seen = r_sticky_of | (~r_sticky_uf & bus.mac_of);
  assign w_uf_seen = r_sticky_uf | (~r_sticky_of & ~bus.mac_of & bus.mac_uf);

  assign w_shifted = bus.mac_acc >>> SHIFT;

`ifdef MAC_CTRL_SAT_EN
  always_comb begin
    w_res = w_shifted[7:0];
    if (w_of_seen)
      w_res = 8'h7F;
    else if (w_uf_seen)
      w_res = 8'h80;
    else if (w_shifted > 16'sd127)
      w_res = 8'h7F;
    else if (w_shifted < -16'sd128)
      w_res = 8'h80;
  end
`else
  logic w_unused_high;
  assign w_unused_high = ^w_shifted[15:8];
  assign w_res         = w_shifted[7:0];
`endif

  // Addresses advance one step ahead of the data they fetch: the memories
  // return address k-1 while the controller is in ACC step k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_k         <= '0;
      r_sticky_of <= 1'b0;
      r_sticky_uf <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_res       <= '0;
      r_res_addr  <= '0;
      r_res_we    <= 1'b0;
      r_in_addr   <= '0;
      r_wt_addr   <= '0;
      r_clr_n     <= 1'b0;
    end else begin
      r_res_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_k    <= '0;
          if (start) begin
            r_state   <= S_CLR;
            r_n       <= '0;
            r_busy    <= 1'b1;
            r_in_addr <= '0;
            r_wt_addr <= '0;
          end
        end
        S_CLR: begin
          r_state     <= S_ACC;
          r_k         <= c_KW'(1);
          r_clr_n     <= 1'b1;
          r_sticky_of <= 1'b0;
          r_sticky_uf <= 1'b0;
          r_in_addr   <= r_in_addr + c_IAW'(1);
          r_wt_addr   <= r_wt_addr + c_WAW'(1);
        end
        S_ACC: begin
          if (r_k >= c_KW'(2)) begin
            r_sticky_of <= w_of_seen;
            r_sticky_uf <= w_uf_seen;
          end
          if (r_k == c_KW'(N_IN)) begin
            // wt_addr is left at base+N_IN, i.e. the next neuron's base.
            r_state <= S_WRITE;
            r_clr_n <= 1'b0;
          end else begin
            r_k       <= r_k + c_KW'(1);
            r_in_addr <= r_in_addr + c_IAW'(1);
            r_wt_addr <= r_wt_addr + c_WAW'(1);
          end
        end
        S_WRITE: begin
          r_sticky_of <= w_of_seen;
          r_sticky_uf <= w_uf_seen;
          r_res       <= w_res;
          r_res_addr  <= r_n;
          r_res_we    <= 1'b1;
          r_k         <= '0;
          if (r_n == c_OAW'(N_OUT - 1)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= S_CLR;
            r_n       <= r_n + c_OAW'(1);
            r_in_addr <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign bus.in_addr   = r_in_addr;
  assign bus.wt_addr   = r_wt_addr;
  assign bus.mac_clr_n = r_clr_n;
  // Accumulate is enabled only in ACC, so the operands are gated on it.
  assign bus.mac_a     = r_clr_n ? bus.in_data : 8'sd0;
  assign bus.mac_b     = r_clr_n ? bus.wt_data : 8'sd0;
  assign bus.res       = r_res;
  assign bus.res_addr  = r_res_addr;
  assign bus.res_we    = r_res_we;
endmodule
`default_nettype wire

// File: tb/tb_mac_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mac_ctrl : self-checking bench for mac_ctrl (N_IN=4, N_OUT=2)         |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_mac_ctrl;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int SHIFT = 4;
  localparam int NW    = N_IN * N_OUT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  mac_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  mac_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SHIFT(SHIFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Environment: synchronous-read memories and a 16-bit wrapping MAC.
  logic signed [7:0]  in_mem [N_IN];
  logic signed [7:0]  wt_mem [NW];
  logic signed [15:0] acc_q = '0;
  logic               of_q  = 1'b0;
  logic               uf_q  = 1'b0;
  int                 mac_sum;

  always @(posedge clk) begin
    bus.in_data <= in_mem[bus.in_addr];
    bus.wt_data <= wt_mem[bus.wt_addr];
    if (!bus.mac_clr_n) begin
      acc_q <= '0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      mac_sum = int'(acc_q) + int'(bus.mac_a) * int'(bus.mac_b);
      acc_q <= 16'(mac_sum);
      of_q  <= (mac_sum > 32767);
      uf_q  <= (mac_sum < -32768);
    end
  end
  assign bus.mac_acc = acc_q;
  assign bus.mac_of  = of_q;
  assign bus.mac_uf  = uf_q;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Operands must be idle whenever the MAC is not accumulating.
  always @(negedge clk) begin
    if (bus.mac_clr_n !== 1'b1)
      check("mac_ab_zero", {16'd0, bus.mac_a, bus.mac_b}, 32'd0);
  end

  // Reference: dot product with 16-bit wrap, first flag wins, then narrowing.
  function automatic logic [7:0] model_res(input int n);
    int acc;
    int s;
    int sh;
`ifdef MAC_CTRL_SAT_EN
    bit of;
    bit uf;
    of = 1'b0;
    uf = 1'b0;
`endif
    acc = 0;
    for (int k = 0; k < N_IN; k++) begin
      s = acc + int'(in_mem[k]) * int'(wt_mem[n * N_IN + k]);
`ifdef MAC_CTRL_SAT_EN
      if (!of && !uf) begin
        of = (s > 32767);
        uf = (s < -32768);
      end
`endif
      acc = ((s + 32768) & 65535) - 32768;
    end
    sh = acc >>> SHIFT;
`ifdef MAC_CTRL_SAT_EN
    if (of) return 8'h7F;
    if (uf) return 8'h80;
    if (sh > 127) return 8'h7F;
    if (sh < -128) return 8'h80;
`endif
    return 8'(sh);
  endfunction

  typedef struct packed {
    logic [N_IN-1:0][7:0] in_v;
    logic [NW-1:0][7:0]   wt_v;
    logic [7:0]           e0;
    logic [7:0]           e1;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < N_IN; k++) in_mem[k] = v.in_v[k];
    for (int k = 0; k < NW; k++)   wt_mem[k] = v.wt_v[k];
  endtask

  // mode 0: plain run; 1: extra start pulse mid-run; 2: start held through done.
  task automatic run_vec(input string nm, input logic [7:0] e0, input logic [7:0] e1, input int mode);
    int         cnt;
    int         nw;
    int         extra;
    bit         got_done;
    logic [7:0] rv [2];
    int         ra [2];
    @(negedge clk);
    start = 1'b1;
    for (int pass = 0; pass < ((mode == 2) ? 2 : 1); pass++) begin
      cnt = 0; nw = 0; got_done = 1'b0;
      rv[0] = 'x; rv[1] = 'x; ra[0] = -1; ra[1] = -1;
      while (!got_done && cnt < 40) begin
        @(negedge clk);
        cnt++;
        if (cnt == 1) begin
          check({nm, " busy_in_clr"}, {31'd0, busy}, 32'd1);
          check({nm, " clr_n_in_clr"}, {31'd0, bus.mac_clr_n}, 32'd0);
          if (mode != 2 || pass == 1) start = 1'b0;
        end
        if (mode == 1 && cnt == 5) start = 1'b1;
        if (mode == 1 && cnt == 6) start = 1'b0;
        if (bus.res_we === 1'b1) begin
          if (nw < 2) begin
            rv[nw] = bus.res;
            ra[nw] = int'(bus.res_addr);
          end
          nw++;
        end
        if (done === 1'b1) begin
          got_done = 1'b1;
          check({nm, " done_cycle"}, cnt, 32'd13);
          check({nm, " done_with_we"}, {31'd0, bus.res_we}, 32'd1);
          check({nm, " busy_in_done"}, {31'd0, busy}, 32'd1);
        end
      end
      start = (mode == 2 && pass == 0) ? 1'b1 : 1'b0;
      check({nm, " done_seen"}, {31'd0, got_done}, 32'd1);
      check({nm, " write_count"}, nw, 32'd2);
      check({nm, " addr0"}, ra[0], 32'd0);
      check({nm, " addr1"}, ra[1], 32'd1);
      check({nm, " res0"}, {24'd0, rv[0]}, {24'd0, e0});
      check({nm, " res1"}, {24'd0, rv[1]}, {24'd0, e1});
    end
    @(negedge clk);
    check({nm, " idle_after"}, {29'd0, busy, done, bus.res_we}, 32'd0);
    if (mode == 1) begin
      extra = 0;
      repeat (20) begin
        @(negedge clk);
        if (done === 1'b1 || bus.res_we === 1'b1 || busy === 1'b1) extra++;
      end
      check({nm, " no_second_run"}, extra, 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         any_we;
    logic [7:0] e0;
    logic [7:0] e1;

    tbl[0].in_v = pk(1, 2, 3, 4);
    tbl[0].wt_v = {pk(-16, -16, -16, -16), pk(16, 16, 16, 16)};
    tbl[0].e0 = 8'h0A; tbl[0].e1 = 8'hF6;
    tbl[1].in_v = pk(127, 127, 127, 127);
    tbl[1].wt_v = {pk(-128, -128, -128, -128), pk(127, 127, 127, 127)};
    tbl[2].in_v = pk(100, 100, 0, 0);
    tbl[2].wt_v = {pk(-20, -20, 0, 0), pk(20, 20, 0, 0)};
`ifdef MAC_CTRL_SAT_EN
    tbl[1].e0 = 8'h7F; tbl[1].e1 = 8'h80;
    tbl[2].e0 = 8'h7F; tbl[2].e1 = 8'h80;
`else
    tbl[1].e0 = 8'hC0; tbl[1].e1 = 8'h20;
    tbl[2].e0 = 8'hFA; tbl[2].e1 = 8'h06;
`endif
    tbl[3].in_v = pk(1, 0, 0, 0);
    tbl[3].wt_v = {pk(-1, 0, 0, 0), pk(15, 0, 0, 0)};
    tbl[3].e0 = 8'h00; tbl[3].e1 = 8'hFF;
    tbl[4].in_v = pk(127, 1, 0, 0);
    tbl[4].wt_v = {pk(-16, -16, 0, 0), pk(16, 0, 0, 0)};
    tbl[4].e0 = 8'h7F; tbl[4].e1 = 8'h80;

    rst_n = 1'b0;
    start = 1'b0;
    load_vec(tbl[0]);
    repeat (3) @(negedge clk);
    check("reset_ctrl", {29'd0, busy, done, bus.res_we}, 32'd0);
    check("reset_res", {23'd0, bus.res, bus.res_addr}, 32'd0);
    check("reset_addr", {27'd0, bus.in_addr, bus.wt_addr}, 32'd0);
    check("reset_mac", {15'd0, bus.mac_clr_n, bus.mac_a, bus.mac_b}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      load_vec(tbl[i]);
      run_vec($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, 0);
    end

    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < N_IN; k++)
        in_mem[k] = (r % 2 == 0) ? 8'($urandom) : 8'(int'($urandom_range(0, 30)) - 15);
      for (int k = 0; k < NW; k++)
        wt_mem[k] = (r % 2 == 0) ? 8'($urandom) : 8'(int'($urandom_range(0, 30)) - 15);
      e0 = model_res(0);
      e1 = model_res(1);
      run_vec($sformatf("rand%0d", r), e0, e1, 0);
    end

    load_vec(tbl[0]);
    run_vec("mid_start", tbl[0].e0, tbl[0].e1, 1);

    // Abort during the ACC phase of neuron 0.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_clr_n", {31'd0, bus.mac_clr_n}, 32'd0);
    check("abort_mac_ab", {16'd0, bus.mac_a, bus.mac_b}, 32'd0);
    any_we = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.res_we !== 1'b0 || done !== 1'b0) any_we++;
    end
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (bus.res_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) any_we++;
    end
    check("abort_no_write", any_we, 32'd0);
    run_vec("rerun", tbl[0].e0, tbl[0].e1, 0);

    load_vec(tbl[1]);
    run_vec("held_start", tbl[1].e0, tbl[1].e1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mac_ctrl.md
MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 SHALL provide parameter N_IN, default 16: products per neuron (>=2); IAW=$clog2(N_IN).
REQ-002 SHALL provide parameter N_OUT, default 4: neurons per run (>=2); OAW=$clog2(N_OUT), WAW=$clog2(N_IN*N_OUT).
REQ-003 SHALL provide parameter SHIFT, default 4: arithmetic right shift applied to the accumulator before narrowing to 8 bits.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-007 SHALL have port busy  output  1  high from the cycle after start is accepted through the done cycle.
REQ-008 SHALL have port done  output  1  one-cycle pulse coincident with the final res_we.
REQ-009 SHALL have port in_addr  output  IAW  input-vector memory address (synchronous read, 1-cycle latency).
REQ-010 SHALL have port in_data  input  8  signed input-vector memory data.
REQ-011 SHALL have port wt_addr  output  WAW  weight memory address = neuron*N_IN + k (1-cycle latency).
REQ-012 SHALL have port wt_data  input  8  signed weight memory data.
REQ-013 SHALL have port mac_a  output  8  signed MAC operand a.
REQ-014 SHALL have port mac_b  output  8  signed MAC operand b.
REQ-015 SHALL have port mac_clr_n  output  1  active-low MAC accumulator clear.
REQ-016 SHALL have port mac_acc  input  16  signed MAC accumulator (MAC adds a*b on every clock while mac_clr_n=1).
REQ-017 SHALL have port mac_of / mac_uf  input  1 each  MAC overflow/underflow of the most recent accumulate (wrapped result).
REQ-018 SHALL have ports res (output 8, signed neuron result), res_addr (output OAW, neuron index), res_we (output 1, one-cycle write strobe).

Function
REQ-019 SHALL implement states IDLE, CLR, ACC, WRITE, with neuron counter n (0..N_OUT-1) and product counter k (0..N_IN).
REQ-020 IDLE: mac_clr_n=0, mac_a=mac_b=0; start=1 at a rising edge -> CLR, n=0; start while not IDLE SHALL be ignored.
REQ-021 CLR (1 cycle): mac_clr_n=0, in_addr=0, wt_addr=n*N_IN, clear sticky flags; -> ACC with k=1.
REQ-022 ACC (N_IN cycles, k=1..N_IN): mac_clr_n=1, mac_a=in_data, mac_b=wt_data (data of address k-1), in_addr=k, wt_addr=n*N_IN+k (address don't-care when k=N_IN); k=N_IN -> WRITE.
REQ-023 SHALL set sticky_of on mac_of=1 and sticky_uf on mac_uf=1 observed in ACC k>=2 or WRITE; the first flag set SHALL win, the other remains clear.
REQ-024 WRITE (1 cycle): mac_clr_n=0, mac_a=mac_b=0; SHALL register res=f(mac_acc, flags), res_addr=n, res_we=1 for exactly the next cycle.
REQ-025 WRITE with n<N_OUT-1 -> CLR with n+1 (res_we overlaps CLR); n=N_OUT-1 -> IDLE with done=1 in the res_we cycle.
REQ-026 Latency: N_IN+2 cycles per neuron; done SHALL assert N_OUT*(N_IN+2)+1 cycles after the accepting edge; start seen in that IDLE cycle SHALL begin a new run.
REQ-027 mac_a/mac_b SHALL be 0 in every cycle except ACC.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, n=k=0, sticky flags 0, and in any state including mid-ACC abort the run with no res_we.
REQ-029 Reset values: busy=0, done=0, res_we=0, res=0, res_addr=0, in_addr=0, wt_addr=0, mac_a=0, mac_b=0, mac_clr_n=0.

Configuration
REQ-030 Macro MAC_CTRL_SAT_EN defined: res=127 if sticky_of, -128 if sticky_uf, else (mac_acc>>>SHIFT) clamped to [-128,127].
REQ-031 Macro MAC_CTRL_SAT_EN undefined: res=(mac_acc>>>SHIFT)[7:0] truncated; mac_of/mac_uf ignored.

Verification (N_IN=4, N_OUT=2, SHIFT=4, MAC_CTRL_SAT_EN defined unless stated)
REQ-032 in=[1,2,3,4], wt0=[16,16,16,16], wt1=[-16,-16,-16,-16] -> res 10 @addr0, -10 (0xF6) @addr1, done 13 cycles after start edge.
REQ-033 in=[127]*4, wt0=[127]*4 (sum 64516, of) -> res 127; wt1=[-128]*4 (uf) -> res -128.
REQ-034 in=[100,100,0,0], wt0=[20,20,0,0] (acc 4000, no of) -> res 127 clamped; MAC_CTRL_SAT_EN undefined -> res 0xFA.
REQ-035 start pulsed again mid-run -> ignored, single done; rst_n low during ACC of neuron 0 -> busy=0, mac_clr_n=0, no res_we; rerun of REQ-032 matches.
REQ-036 start held high -> second run's CLR begins the cycle after done; mac_a=mac_b=0 checked every non-ACC cycle.
